// File: rtl/led_scan_driver.sv
// Four-digit common-anode scan driver: BLANK/ON FSM with frame-boundary commit of a shadow value.
// Registered outputs; no backpressure. `LED_SCAN_LEADING_ZERO_BLANK_EN` suppresses leading-zero digits.
module led_scan_driver #(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame
);
    localparam int MAX_CYCLES = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t             state_q, state_d;
    logic [1:0]         digit_q, digit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        disp_q, disp_d;
    logic [15:0]        shadow_q, shadow_d;
    logic               pend_q, pend_d;
    logic [3:0]         an_q, an_d;
    logic [3:0]         char_q, char_d;
    logic               frame_q, frame_d;
    logic               lz_blank;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd3:    nibble = v[15:12];
            2'd2:    nibble = v[11:8];
            2'd1:    nibble = v[7:4];
            default: nibble = v[3:0];
        endcase
    endfunction

`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        lz_blank = 1'b0;
        case (digit_q)
            2'd3:    lz_blank = (disp_q[15:12] == 4'h0);
            2'd2:    lz_blank = (disp_q[15:8] == 8'h00);
            2'd1:    lz_blank = (disp_q[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cnt_d    = cnt_q + 1'b1;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        an_d     = an_q;
        char_d   = char_q;
        frame_d  = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    an_d    = lz_blank ? 4'b1111 : ~(4'b0001 << digit_q);
                    frame_d = (digit_q == 2'd3);
                end
            end
            default: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    an_d    = 4'b1111;
                    digit_d = digit_q - 2'd1;
                    // Commit at the end of digit 0 so the next frame starts with a consistent value.
                    if (digit_q == 2'd0 && pend_q) begin
                        disp_d = shadow_q;
                        pend_d = 1'b0;
                        char_d = shadow_q[15:12];
                    end else begin
                        char_d = nibble(disp_q, digit_q - 2'd1);
                    end
                end
            end
        endcase

        // A load on the commit edge lands in the shadow after the old one has been committed.
        if (load) begin
            shadow_d = data_in;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_BLANK;
            digit_q  <= 2'd3;
            cnt_q    <= '0;
            disp_q   <= 16'h0000;
            shadow_q <= 16'h0000;
            pend_q   <= 1'b0;
            an_q     <= 4'b1111;
            char_q   <= 4'h0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            char_q   <= char_d;
            frame_q  <= frame_d;
        end
    end

    assign an      = an_q;
    assign char    = char_q;
    assign pending = pend_q;
    assign frame   = frame_q;
endmodule
